// File: rtl/reversible_adder_pipe_if.sv
// Operand/result bus for reversible_adder_pipe: input beat handshake, result
// beat handshake and the consumed-beat counter.
interface reversible_adder_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] anc;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] g_a;
  logic [WIDTH-1:0] g_ab;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, mode, a, b, anc, cin, out_ready,
    input  in_ready, out_valid, sum, cout, g_a, g_ab, op_count
  );

  modport slave (
    input  in_valid, mode, a, b, anc, cin, out_ready,
    output in_ready, out_valid, sum, cout, g_a, g_ab, op_count
  );
endinterface

// File: rtl/reversible_adder_pipe.sv
// Two-stage elastic reversible adder/subtractor with garbage lines (g_a, g_ab).
// Optional macro REV_ANC_CHECK_EN adds the sticky dirty-ancilla flag anc_err.
module reversible_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef REV_ANC_CHECK_EN
  output logic                   anc_err,
`endif
  reversible_adder_pipe_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q,  s1_mode_d;
  logic             s1_cin_q,   s1_cin_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [WIDTH-1:0] s1_anc_q,   s1_anc_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_sum_q,   s2_sum_d;
  logic             s2_cout_q,  s2_cout_d;
  logic [WIDTH-1:0] s2_ga_q,    s2_ga_d;
  logic [WIDTH-1:0] s2_gab_q,   s2_gab_d;
  logic [CNT_W-1:0] count_q,    count_d;

  logic             s1_adv_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   res_s;

  assign s1_adv_s   = s1_valid_q & (~s2_valid_q | bus.out_ready);
  assign bus.in_ready = ~reset & (~s1_valid_q | s1_adv_s);
  assign in_fire_s  = bus.in_valid & bus.in_ready;
  assign out_fire_s = s2_valid_q & bus.out_ready;

  // Bit WIDTH of the subtraction is the borrow-out: it is set exactly when a < b + cin.
  always_comb begin
    add_s = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q};
    sub_s = {1'b0, s1_a_q} - {1'b0, s1_b_q} - {{WIDTH{1'b0}}, s1_cin_q};
    if (s1_mode_q) begin
      res_s = sub_s;
    end else begin
      res_s = add_s;
    end
  end

  always_comb begin
    s1_valid_d = in_fire_s | (s1_valid_q & ~s1_adv_s);
    s2_valid_d = s1_adv_s | (s2_valid_q & ~out_fire_s);
    s1_mode_d  = s1_mode_q;
    s1_cin_d   = s1_cin_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_anc_d   = s1_anc_q;
    s2_sum_d   = s2_sum_q;
    s2_cout_d  = s2_cout_q;
    s2_ga_d    = s2_ga_q;
    s2_gab_d   = s2_gab_q;
    count_d    = count_q;
    if (in_fire_s) begin
      s1_mode_d = bus.mode;
      s1_cin_d  = bus.cin;
      s1_a_d    = bus.a;
      s1_b_d    = bus.b;
      s1_anc_d  = bus.anc;
    end else begin
      s1_mode_d = s1_mode_q;
    end
    if (s1_adv_s) begin
      s2_sum_d  = res_s[WIDTH-1:0];
      s2_cout_d = res_s[WIDTH];
      s2_ga_d   = s1_a_q;
      s2_gab_d  = s1_a_q ^ s1_b_q ^ s1_anc_q;
    end else begin
      s2_sum_d  = s2_sum_q;
    end
    if (out_fire_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Pipeline state; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_cin_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_anc_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cout_q  <= 1'b0;
      s2_ga_q    <= '0;
      s2_gab_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_cin_q   <= s1_cin_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_anc_q   <= s1_anc_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_cout_q  <= s2_cout_d;
      s2_ga_q    <= s2_ga_d;
      s2_gab_q   <= s2_gab_d;
      count_q    <= count_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = s2_sum_q;
  assign bus.cout      = s2_cout_q;
  assign bus.g_a       = s2_ga_q;
  assign bus.g_ab      = s2_gab_q;
  assign bus.op_count  = count_q;

`ifdef REV_ANC_CHECK_EN
  logic anc_err_q, anc_err_d;

  assign anc_err_d = anc_err_q | (in_fire_s & (|bus.anc));

  // Sticky flag: any accepted beat carrying a dirty ancilla latches it until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      anc_err_q <= 1'b0;
    end else begin
      anc_err_q <= anc_err_d;
    end
  end

  assign anc_err = anc_err_q;
`else
  // Ancilla is passed through to g_ab only; no check logic in this build.
`endif

endmodule

// File: tb/tb_reversible_adder_pipe.sv
// Directed self-checking bench: 8-bit instance for datapath/handshake/reset,
// 16-bit instance with a 2-bit counter for wrap and reversibility.
module tb_reversible_adder_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reversible_adder_pipe_if #(.WIDTH(8),  .CNT_W(16)) bus0 ();
  reversible_adder_pipe_if #(.WIDTH(16), .CNT_W(2))  bus1 ();

`ifdef REV_ANC_CHECK_EN
  logic anc_err0;
  logic anc_err1;
`endif

  reversible_adder_pipe #(.WIDTH(8), .CNT_W(16)) dut0 (
    .clk     (clk),
    .reset   (reset),
`ifdef REV_ANC_CHECK_EN
    .anc_err (anc_err0),
`endif
    .bus     (bus0.slave)
  );

  reversible_adder_pipe #(.WIDTH(16), .CNT_W(2)) dut1 (
    .clk     (clk),
    .reset   (reset),
`ifdef REV_ANC_CHECK_EN
    .anc_err (anc_err1),
`endif
    .bus     (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic m, input logic [7:0] av,
                        input logic [7:0] bv, input logic ci, input logic [7:0] an);
    bus0.in_valid = v;
    bus0.mode     = m;
    bus0.a        = av;
    bus0.b        = bv;
    bus0.cin      = ci;
    bus0.anc      = an;
  endtask

  // One beat through the 16-bit instance with out_ready held high.
  task automatic run1(input logic m, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, output logic [15:0] s, output logic co);
    bus1.in_valid  = 1'b1;
    bus1.mode      = m;
    bus1.a         = av;
    bus1.b         = bv;
    bus1.cin       = ci;
    bus1.anc       = 16'h0000;
    bus1.out_ready = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    step();
    chk("w16_out_valid", {31'd0, bus1.out_valid}, 32'd1);
    s  = bus1.sum;
    co = bus1.cout;
    step();
  endtask

  logic [7:0]  bp_a   [4];
  logic [7:0]  bp_b   [4];
  logic [7:0]  bp_exp [4];
  logic [1:0]  cnt_exp [5];
  logic [15:0] ra, rb, rs, rs2;
  logic        rc, rco, rco2;
  logic [16:0] model;

  initial begin
    bp_a   = '{8'h01, 8'h02, 8'h03, 8'h04};
    bp_b   = '{8'h10, 8'h20, 8'h30, 8'h40};
    bp_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    reset = 1'b1;
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.mode = 1'b0; bus1.a = 16'h0000; bus1.b = 16'h0000;
    bus1.cin = 1'b0; bus1.anc = 16'h0000; bus1.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready",  {31'd0, bus0.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_sum",       {24'd0, bus0.sum},       32'd0);
    chk("rst_cout",      {31'd0, bus0.cout},      32'd0);
    chk("rst_op_count",  {16'd0, bus0.op_count},  32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);

    // Add with carry out: FF + 01 + 0
    drive0(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00);
    bus0.out_ready = 1'b1;
    step();
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("lat_not_yet", {31'd0, bus0.out_valid}, 32'd0);
    step();
    chk("add_valid", {31'd0, bus0.out_valid}, 32'd1);
    chk("add_sum",   {24'd0, bus0.sum},       32'h00);
    chk("add_cout",  {31'd0, bus0.cout},      32'd1);
    chk("add_g_a",   {24'd0, bus0.g_a},       32'hFF);
    chk("add_g_ab",  {24'd0, bus0.g_ab},      32'hFE);
    step();
    chk("add_consumed", {31'd0, bus0.out_valid}, 32'd0);
    chk("add_op_count", {16'd0, bus0.op_count},  32'd1);

    // Two back-to-back subtracts: with and without borrow out
    drive0(1'b1, 1'b1, 8'h05, 8'h07, 1'b1, 8'h00);
    step();
    drive0(1'b1, 1'b1, 8'h10, 8'h03, 1'b0, 8'h00);
    step();
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("sub1_valid", {31'd0, bus0.out_valid}, 32'd1);
    chk("sub1_sum",   {24'd0, bus0.sum},       32'hFD);
    chk("sub1_cout",  {31'd0, bus0.cout},      32'd1);
    chk("sub1_g_ab",  {24'd0, bus0.g_ab},      32'h02);
    step();
    chk("sub2_valid", {31'd0, bus0.out_valid}, 32'd1);
    chk("sub2_sum",   {24'd0, bus0.sum},       32'h0D);
    chk("sub2_cout",  {31'd0, bus0.cout},      32'd0);
    chk("sub2_g_a",   {24'd0, bus0.g_a},       32'h10);
    step();
    chk("sub_op_count", {16'd0, bus0.op_count}, 32'd3);
    chk("idle_hold_sum", {24'd0, bus0.sum},     32'h0D);

    // Beat accepted, then reset on the next edge discards it
    drive0(1'b1, 1'b0, 8'hAA, 8'h55, 1'b1, 8'h00);
    step();
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, bus0.in_ready}, 32'd0);
    step();
    reset = 1'b0;
    chk("mid_rst_op_count", {16'd0, bus0.op_count}, 32'd0);
    chk("mid_rst_sum",      {24'd0, bus0.sum},      32'd0);
    chk("mid_rst_cout",     {31'd0, bus0.cout},     32'd0);
    chk("mid_rst_g_a",      {24'd0, bus0.g_a},      32'd0);
    chk("mid_rst_g_ab",     {24'd0, bus0.g_ab},     32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_valid", {31'd0, bus0.out_valid}, 32'd0);
      step();
    end

    // Four back-to-back beats with a three-cycle stall after the first result
    bus0.out_ready = 1'b1;
    drive0(1'b1, 1'b0, bp_a[0], bp_b[0], 1'b0, 8'h00);
    step();
    drive0(1'b1, 1'b0, bp_a[1], bp_b[1], 1'b0, 8'h00);
    step();
    bus0.out_ready = 1'b0;
    drive0(1'b1, 1'b0, bp_a[2], bp_b[2], 1'b0, 8'h00);
    #1;
    chk("bp_full_in_ready", {31'd0, bus0.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, bus0.out_valid}, 32'd1);
      chk("bp_hold_sum",   {24'd0, bus0.sum},       32'h11);
      chk("bp_hold_ready", {31'd0, bus0.in_ready},  32'd0);
    end
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_order_valid", {31'd0, bus0.out_valid}, 32'd1);
      chk("bp_order_sum",   {24'd0, bus0.sum},       {24'd0, bp_exp[i]});
      step();
      if (i == 0) begin
        drive0(1'b1, 1'b0, bp_a[3], bp_b[3], 1'b0, 8'h00);
      end else if (i == 1) begin
        drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      end
    end
    chk("bp_drained",   {31'd0, bus0.out_valid}, 32'd0);
    chk("bp_op_count",  {16'd0, bus0.op_count},  32'd4);

`ifdef REV_ANC_CHECK_EN
    chk("anc_clean", {31'd0, anc_err0}, 32'd0);
    drive0(1'b1, 1'b0, 8'h01, 8'h02, 1'b0, 8'h01);
    step();
    drive0(1'b1, 1'b0, 8'h03, 8'h04, 1'b0, 8'h00);
    chk("anc_set", {31'd0, anc_err0}, 32'd1);
    step();
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("anc_g_ab", {24'd0, bus0.g_ab}, 32'h02);
    chk("anc_sum",  {24'd0, bus0.sum},  32'h03);
    step();
    step();
    chk("anc_sticky", {31'd0, anc_err0}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("anc_cleared", {31'd0, anc_err0}, 32'd0);
`endif

    // 16-bit: counter wrap 1,2,3,0,1 plus add/subtract round trips
    ra = 16'h1234; rb = 16'hFEDC; rc = 1'b1;
    run1(1'b0, ra, rb, rc, rs, rco);
    chk("w16_add_sum",  {16'd0, rs},  32'h1111);
    chk("w16_add_cout", {31'd0, rco}, 32'd1);
    chk("w16_cnt0", {30'd0, bus1.op_count}, {30'd0, cnt_exp[0]});
    run1(1'b1, rs, rb, rc, rs2, rco2);
    chk("w16_rev_sum",  {16'd0, rs2},  32'h1234);
    chk("w16_rev_cout", {31'd0, rco2}, 32'd1);
    chk("w16_cnt1", {30'd0, bus1.op_count}, {30'd0, cnt_exp[1]});
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
    model = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
    run1(1'b0, ra, rb, rc, rs, rco);
    chk("w16_rnd_add", {15'd0, rco, rs}, {15'd0, model});
    chk("w16_cnt2", {30'd0, bus1.op_count}, {30'd0, cnt_exp[2]});
    run1(1'b1, rs, rb, rc, rs2, rco2);
    chk("w16_rnd_rev", {16'd0, rs2}, {16'd0, ra});
    chk("w16_cnt3", {30'd0, bus1.op_count}, {30'd0, cnt_exp[3]});
    run1(1'b0, 16'h0001, 16'h0002, 1'b0, rs, rco);
    chk("w16_small_sum", {16'd0, rs}, 32'h0003);
    chk("w16_cnt4", {30'd0, bus1.op_count}, {30'd0, cnt_exp[4]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reversible_adder_pipe.md
REVERSIBLE_ADDER_PIPE -- requirements
Module: reversible_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/ancilla width, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 16, width of op_count.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid&in_ready.
REQ-007 SHALL have port mode  input  1  0 = add (compute), 1 = subtract (uncompute).
REQ-008 SHALL have ports a, b, anc  input  WIDTH  operands and ancilla (expected zero).
REQ-009 SHALL have port cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 SHALL have port out_valid  output  1  result beat offered.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready.
REQ-012 SHALL have ports sum  output  WIDTH, cout  output  1, g_a  output  WIDTH, g_ab  output  WIDTH  result and garbage lines.
REQ-013 SHALL have port op_count  output  CNT_W  count of consumed result beats.
REQ-014 SHALL have port anc_err  output  1  sticky dirty-ancilla flag (present only with macro, REQ-030).

Function
REQ-015 SHALL be a two-stage elastic pipeline: stage S1 registers accepted inputs, stage S2 registers the computed result; each stage has its own valid bit.
REQ-016 SHALL advance S1->S2 when S1 valid and (S2 empty or out_ready); in_ready SHALL equal !S1_valid or S1 advancing (combinational, no dependence on in_valid).
REQ-017 SHALL present a beat accepted at edge k on out_valid from edge k+2 when out_ready held high; throughput one beat/cycle.
REQ-018 SHALL hold sum, cout, g_a, g_ab stable while out_valid&!out_ready; no beat dropped or duplicated.
REQ-019 mode=0: {cout,sum} SHALL equal a + b + cin, WIDTH+1-bit result.
REQ-020 mode=1: sum SHALL equal (a - b - cin) mod 2^WIDTH; cout SHALL be 1 iff a < b + cin (borrow out).
REQ-021 g_a SHALL equal registered a; g_ab SHALL equal a XOR b XOR anc for both modes.
REQ-022 Add then subtract with same b, cin: second sum SHALL equal original a (reversibility).
REQ-023 op_count SHALL increment by 1 on each out_valid&out_ready edge, wrapping 2^CNT_W-1 -> 0.
REQ-024 Simultaneous accept and consume on a full pipeline SHALL sustain full throughput with no bubble.
REQ-025 Outputs when out_valid low are don't-care for consumers, but SHALL hold last value (no X after reset).

Reset
REQ-026 reset SHALL clear S1/S2 valid bits, sum, g_a, g_ab, op_count to 0, cout to 0, anc_err to 0.
REQ-027 During reset in_ready SHALL be 0; first acceptance possible on the cycle after reset deasserts.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no out_valid for them afterwards.
REQ-029 reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-030 Macro REV_ANC_CHECK_EN: when defined, anc_err port exists and SHALL set (sticky until reset) on the edge an accepted beat has anc != 0; result computation unchanged.
REQ-031 Without REV_ANC_CHECK_EN: anc_err port absent, no check logic, all other behaviour identical.

Verification
REQ-032 WIDTH=8, mode=0, a=0xFF, b=0x01, cin=0, out_ready=1 -> two edges later out_valid=1, sum=0x00, cout=1, g_a=0xFF, g_ab=0xFE.
REQ-033 mode=1, a=0x05, b=0x07, cin=1 -> sum=0xFD, cout=1; then mode=1 a=0x10 b=0x03 cin=0 -> sum=0x0D, cout=0.
REQ-034 4 back-to-back beats, out_ready low 3 cycles after first out_valid -> in_ready drops after 2 beats buffered, all 4 results delivered in order, op_count=4.
REQ-035 Beat accepted, reset asserted next cycle -> out_valid never asserts for that beat, op_count=0, all outputs 0.
REQ-036 With REV_ANC_CHECK_EN, anc=0x01 on one beat -> anc_err=1 from next edge, remains 1 across later clean beats until reset.
REQ-037 WIDTH=16, CNT_W=2, 5 consumed beats -> op_count sequence 1,2,3,0,1; random add/sub pairs -> REQ-022 holds.
